// File: rtl/toom3_pkg.sv
// Shared widths, the exact-division constant and the FSM state type for the
// Toom-Cook-3 interpolation engine.
package toom3_pkg;
  localparam int LIMB  = 64;
  localparam int GUARD = 8;
  localparam int VW    = 2 * LIMB + GUARD;  // must be even
  localparam int RW    = 6 * LIMB;

  // Multiplicative inverse of 3 modulo 2^VW: 0xAA..AB
  localparam logic [VW-1:0] INV3 = {{(VW/2-1){2'b10}}, 2'b11};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUB  = 3'd1,
    DIV  = 3'd2,
    MID  = 3'd3,
    FIN  = 3'd4,
    SUM  = 3'd5,
    OUT  = 3'd6
  } tc3_state_t;

  // Sign-extend a VW-bit coefficient to the full result width
  function automatic logic [RW-1:0] sext(input logic [VW-1:0] x);
    return {{(RW-VW){x[VW-1]}}, x};
  endfunction
endpackage

// File: rtl/toom3_exact_div3.sv
// Exact division by 3 as a multiply by the modular inverse; only correct when
// the dividend is a multiple of 3, otherwise yields defined garbage.
module toom3_exact_div3
  import toom3_pkg::*;
(
  input  logic [VW-1:0] a_i,
  output logic [VW-1:0] q_o
);
  // Low VW bits of a_i * INV3
  assign q_o = a_i * INV3;
endmodule

// File: rtl/toom3_interp_seq.sv
// Sequential Bodrato interpolation: five point-products in, 6-limb product out.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; out_valid stays high with result/out_err stable until out_ready is seen.
module toom3_interp_seq
  import toom3_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VW-1:0]   v0,
  input  logic [VW-1:0]   v1,
  input  logic [VW-1:0]   vm1,
  input  logic [VW-1:0]   vm2,
  input  logic [VW-1:0]   vinf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   result,
  output logic            out_err,
  output tc3_state_t      state_o
);

  tc3_state_t state_q, state_d;

  logic signed [VW-1:0] r0_q, r1_q, r2_q, r3_q, r4_q;
  logic signed [VW-1:0] r0_d, r1_d, r2_d, r3_d, r4_d;
  logic [RW-1:0]        result_q, result_d;
  logic                 err_q, err_d;
  logic [VW-1:0]        div3_q;

  toom3_exact_div3 u_div3 (
    .a_i (r3_q),
    .q_o (div3_q)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign out_err   = err_q;
  assign state_o   = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one step per cycle, waits in IDLE for input and in OUT for the sink
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SUB;
      SUB:     state_d = DIV;
      DIV:     state_d = MID;
      MID:     state_d = FIN;
      FIN:     state_d = SUM;
      SUM:     state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Interpolation datapath: r registers hold the raw inputs after accept, then
  // are rewritten in place by each step of the sequence
  always_comb begin
    r0_d     = r0_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    r4_d     = r4_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r0_d = v0;
          r1_d = v1;
          r2_d = vm1;
          r3_d = vm2;
          r4_d = vinf;
        end
      end
      SUB: begin
        r3_d = r3_q - r1_q;  // vm2 - v1
        r1_d = r1_q - r2_q;  // v1 - vm1
        r2_d = r2_q - r0_q;  // vm1 - v0
      end
      DIV: begin
        r3_d = div3_q;
        r1_d = r1_q >>> 1;
      end
      MID: begin
        r3_d = ((r2_q - r3_q) >>> 1) + (r4_q <<< 1);
      end
      FIN: begin
        r2_d = r2_q + r1_q - r4_q;
        r1_d = r1_q - r3_q;
      end
      SUM: begin
        result_d = sext(r0_q)
                 + (sext(r1_q) << LIMB)
                 + (sext(r2_q) << (2*LIMB))
                 + (sext(r3_q) << (3*LIMB))
                 + (sext(r4_q) << (4*LIMB));
        err_d    = r1_q[VW-1] | r2_q[VW-1] | r3_q[VW-1];
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_q     <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      r4_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      r4_q     <= r4_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_toom3_interp_seq.sv
// Self-checking bench for toom3_interp_seq: directed cases plus random
// operand pairs whose expected result is the plain 192x192 product.
module tb_toom3_interp_seq;
  import toom3_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready, out_err;
  logic [VW-1:0]   v0, v1, vm1, vm2, vinf;
  logic [RW-1:0]   result;
  tc3_state_t      state_o;

  toom3_interp_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v0        (v0),
    .v1        (v1),
    .vm1       (vm1),
    .vm2       (vm2),
    .vinf      (vinf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_err   (out_err),
    .state_o   (state_o)
  );

  // Scoreboard
  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_err_q[$];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present a point-product set and wait for it to be accepted
  task automatic send(input logic [VW-1:0] a_v0, input logic [VW-1:0] a_v1,
                      input logic [VW-1:0] a_vm1, input logic [VW-1:0] a_vm2,
                      input logic [VW-1:0] a_vinf);
    int n;
    n = 0;
    v0 = a_v0; v1 = a_v1; vm1 = a_vm1; vm2 = a_vm2; vinf = a_vinf;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("accept_bound", RW'(n < 20), RW'(1));
    step();
    in_valid = 1'b0;
  endtask

  // Compare the presented result against the scoreboard and complete the handshake
  task automatic finish_out(input string tag);
    logic [RW-1:0] e, ee;
    e  = '0;
    ee = '0;
    chk({tag, "_q_nonempty"}, RW'(exp_q.size() > 0), RW'(1));
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ee = exp_err_q.pop_front();
    end
    chk({tag, "_valid"}, RW'(out_valid), RW'(1));
    chk({tag, "_result"}, result, e);
    chk({tag, "_err"}, RW'(out_err), ee);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, RW'(out_valid), RW'(0));
    chk({tag, "_done_ready"}, RW'(in_ready), RW'(1));
  endtask

  task automatic recv(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, RW'(n), RW'(5));
    finish_out(tag);
  endtask

  // Reference: value of a 3-limb polynomial at small integer x, signed VW bits
  function automatic logic signed [VW-1:0] ev(input logic [LIMB-1:0] l0, input logic [LIMB-1:0] l1,
                                               input logic [LIMB-1:0] l2, input int x);
    logic signed [VW-1:0] s0, s1, s2, xs;
    s0 = VW'(l0);
    s1 = VW'(l1);
    s2 = VW'(l2);
    xs = VW'(x);
    return s0 + xs * s1 + xs * xs * s2;
  endfunction

  task automatic random_op(input string tag);
    logic [LIMB-1:0] a0, a1, a2, b0, b1, b2;
    logic [RW-1:0] aa, bb;
    logic signed [VW-1:0] p0, p1, pm1, pm2, pinf;
    a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom};
    b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) a2 = {LIMB{1'b1}};
    aa = {{(3*LIMB){1'b0}}, a2, a1, a0};
    bb = {{(3*LIMB){1'b0}}, b2, b1, b0};
    p0   = ev(a0, a1, a2, 0)  * ev(b0, b1, b2, 0);
    p1   = ev(a0, a1, a2, 1)  * ev(b0, b1, b2, 1);
    pm1  = ev(a0, a1, a2, -1) * ev(b0, b1, b2, -1);
    pm2  = ev(a0, a1, a2, -2) * ev(b0, b1, b2, -2);
    pinf = ev(a2, a2, a2, 0)  * ev(b2, b2, b2, 0);
    exp_q.push_back(aa * bb);
    exp_err_q.push_back('0);
    send(p0, p1, pm1, pm2, pinf);
    recv(tag);
  endtask

  logic [RW-1:0]  one_r, e4, e5, held;
  logic [VW-1:0]  m2;

  initial begin
    one_r = RW'(1);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    v0 = '0; v1 = '0; vm1 = '0; vm2 = '0; vinf = '0;
    step();
    step();
    chk("reset_in_ready", RW'(in_ready), RW'(1));
    chk("reset_out_valid", RW'(out_valid), RW'(0));
    chk("reset_out_err", RW'(out_err), RW'(0));
    chk("reset_result", result, RW'(0));
    rst = 1'b0;
    step();

    // a=b=1
    exp_q.push_back(one_r); exp_err_q.push_back('0);
    send(VW'(1), VW'(1), VW'(1), VW'(1), VW'(0));
    chk("busy_in_ready", RW'(in_ready), RW'(0));
    recv("one");

    // a=b=2^64, out_ready held high early
    out_ready = 1'b1;
    exp_q.push_back(one_r << 128); exp_err_q.push_back('0);
    send(VW'(0), VW'(1), VW'(1), VW'(4), VW'(0));
    out_ready = 1'b0;
    recv("limb1");

    // a=b=2^128 (negative intermediate in MID)
    exp_q.push_back(one_r << 256); exp_err_q.push_back('0);
    send(VW'(0), VW'(1), VW'(1), VW'(16), VW'(1));
    recv("limb2");

    // a=b=2^192-1
    m2 = VW'({LIMB{1'b1}}) * VW'({LIMB{1'b1}});
    e4 = RW'(0) - (one_r << 193) + one_r;
    exp_q.push_back(e4); exp_err_q.push_back('0);
    send(m2, m2 * VW'(9), m2, m2 * VW'(9), m2);
    recv("allones");

    // Inconsistent set: r1 ends at -2, flagged; output stalled for 10 cycles
    e5 = (one_r << 192) + (one_r << 128) - (RW'(2) << 64);
    exp_q.push_back(e5); exp_err_q.push_back(RW'(1));
    send(VW'(0), VW'(0), VW'(2), VW'(0), VW'(0));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      chk("err_latency", RW'(n), RW'(5));
    end
    held = result;
    v0 = VW'(7); v1 = VW'(7); vm1 = VW'(7); vm2 = VW'(7); vinf = VW'(7);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", RW'(out_valid), RW'(1));
      chk("stall_result", result, held);
      chk("stall_in_ready", RW'(in_ready), RW'(0));
    end
    in_valid = 1'b0;
    finish_out("err");
    step();
    chk("ignored_no_output", RW'(out_valid), RW'(0));

    // Reset while in DIV aborts the operation
    send(VW'(0), VW'(1), VW'(1), VW'(4), VW'(0));
    step();
    chk("abort_in_div", RW'(state_o), RW'(DIV));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", RW'(out_valid), RW'(0));
    chk("abort_in_ready", RW'(in_ready), RW'(1));
    chk("abort_out_err", RW'(out_err), RW'(0));
    chk("abort_result", result, RW'(0));
    exp_q.push_back(one_r << 128); exp_err_q.push_back('0);
    send(VW'(0), VW'(1), VW'(1), VW'(4), VW'(0));
    recv("after_abort");

    // Random operand pairs
    for (int k = 0; k < 8; k++) random_op("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
